// File: rtl/counter_readout_seq_pkg.sv
// Shared types and constants for the counter readout sequencer.
// Holds the FSM state encoding, default geometry and the frame-length helper.
package counter_readout_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNAP  = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int NCH_DEF    = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int ADDR_W_DEF = 4;

  // SNAP + DONE, plus one LOAD and CNT_W SHIFT cycles per channel.
  function automatic int frame_len(input int nch, input int cnt_w);
    return 2 + nch * (1 + cnt_w);
  endfunction

endpackage

// File: rtl/counter_readout_seq_if.sv
// Chip-level readout pins of the counter readout sequencer, plus a debug view of its FSM state.
// Handshake: cnt_data is a combinational function of addr and is sampled at the end of every sl=0 cycle.
interface counter_readout_seq_if #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 4
);
  import counter_readout_pkg::*;

  logic              rtc;
  logic [CNT_W-1:0]  cnt_data;
  logic [ADDR_W-1:0] addr;
  logic              snap;
  logic              sl;
  logic              ser_out;
  logic              busy;
  logic              frame_done;
  logic              ovf_rtc;
  state_e            state;

  modport slave (
    input  rtc, cnt_data,
    output addr, snap, sl, ser_out, busy, frame_done, ovf_rtc, state
  );

  modport master (
    output rtc, cnt_data,
    input  addr, snap, sl, ser_out, busy, frame_done, ovf_rtc, state
  );

endinterface

// File: rtl/counter_readout_seq_piso.sv
// Parallel-load, MSB-first shift register feeding the serial readout line.
module readout_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_shreg[W-1];

endmodule

// File: rtl/counter_readout_seq.sv
// Readout sequencer: on each RTC rising edge, snapshot all channels and shift every
// channel count out MSB-first while walking the channel address 0..NCH-1.
module counter_readout_seq
  import counter_readout_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_readout_seq_if.slave  bus
);

  localparam int BW = (CNT_W > 2) ? $clog2(CNT_W) : 1;
  localparam logic [BW-1:0]     LAST_BIT  = BW'(CNT_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCH - 1);

  state_e            r_state;
  state_e            w_next;
  logic              r_rtc_q;
  logic [ADDR_W-1:0] r_addr;
  logic [BW-1:0]     r_bitcnt;
  logic              r_ovf;
  logic              w_tick;
  logic              w_last_bit;
  logic              w_last_ch;
  logic              w_msb;

  // r_rtc_q resets high so an rtc already asserted at reset release is not a tick.
  assign w_tick     = bus.rtc & ~r_rtc_q;
  assign w_last_bit = (r_bitcnt == LAST_BIT);
  assign w_last_ch  = (r_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_next = SNAP;
      SNAP:    w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_last_bit) w_next = w_last_ch ? DONE : LOAD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rtc_q  <= 1'b1;
      r_addr   <= '0;
      r_bitcnt <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_rtc_q <= bus.rtc;
      // A tick outside IDLE is recorded but never restarts the frame.
      if (w_tick && (r_state != IDLE)) r_ovf <= 1'b1;
      case (r_state)
        SNAP:  r_addr <= '0;
        LOAD:  r_bitcnt <= '0;
        SHIFT: begin
          r_bitcnt <= r_bitcnt + 1'b1;
          if (w_last_bit && !w_last_ch) r_addr <= r_addr + 1'b1;
        end
        DONE:  r_addr <= '0;
        default: ;
      endcase
    end
  end

  readout_piso #(.W(CNT_W)) u_piso (
    .clk     (clk),
    .reset   (reset),
    .i_load  (r_state == LOAD),
    .i_shift (r_state == SHIFT),
    .i_data  (bus.cnt_data),
    .o_msb   (w_msb)
  );

  always_comb begin
    bus.snap       = 1'b0;
    bus.sl         = 1'b1;
    bus.ser_out    = 1'b0;
    bus.frame_done = 1'b0;
    bus.busy       = (r_state != IDLE);
    case (r_state)
      SNAP:    bus.snap = 1'b1;
      LOAD:    bus.sl = 1'b0;
      SHIFT:   bus.ser_out = w_msb;
      DONE:    bus.frame_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.addr    = r_addr;
  assign bus.ovf_rtc = r_ovf;
  assign bus.state   = r_state;

endmodule
